// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/return state, trap vector generation and
// the 64-bit cycle / instret counters, with a single read-modify-write port.
module csr_file #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret_valid,
    input  logic            instret_inc,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] epc_out,
    output logic            mie_out
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [63:0]     r_mcycle;
    logic [63:0]     r_minstret;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic [63:0]     w_new64;
    logic            w_legal;
    logic            w_wr;
    logic [63:0]     w_cycle_nxt;
    logic [63:0]     w_instret_nxt;
    logic [XLEN-1:0] w_tv_base;
    logic [XLEN-1:0] w_tv_off;

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    // Address decode and pre-update read value; unimplemented addresses read 0.
    always_comb begin
        w_legal = 1'b1;
        w_old   = '0;
        case (csr_addr)
            ADDR_MSTATUS:  w_old = w_mstatus;
            ADDR_MTVEC:    w_old = r_mtvec;
            ADDR_MSCRATCH: w_old = r_mscratch;
            ADDR_MEPC:     w_old = r_mepc;
            ADDR_MCAUSE:   w_old = r_mcause;
            ADDR_MTVAL:    w_old = r_mtval;
            ADDR_MCYCLE:   w_old = XLEN'(r_mcycle);
            ADDR_MINSTRET: w_old = XLEN'(r_minstret);
            ADDR_MCYCLEH: begin
                if (XLEN == 32) w_old = XLEN'(r_mcycle[63:32]);
                else            w_legal = 1'b0;
            end
            ADDR_MINSTRETH: begin
                if (XLEN == 32) w_old = XLEN'(r_minstret[63:32]);
                else            w_legal = 1'b0;
            end
            default:       w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_old | csr_wdata;
            2'b11:   w_new = w_old & ~csr_wdata;
            default: w_new = w_old;
        endcase
    end

    assign w_new64     = 64'(w_new);
    assign w_wr        = (csr_op != 2'b00) && w_legal;
    assign csr_illegal = (csr_op != 2'b00) && !w_legal;
    assign csr_rdata   = w_old;

    // A write to either counter half freezes the whole counter for that cycle.
    always_comb begin
        w_cycle_nxt   = r_mcycle + 64'd1;
        w_instret_nxt = r_minstret + {63'd0, instret_inc};
        if (w_wr) begin
            case (csr_addr)
                ADDR_MCYCLE:    w_cycle_nxt   = (XLEN == 32) ? {r_mcycle[63:32], w_new64[31:0]} : w_new64;
                ADDR_MCYCLEH:   w_cycle_nxt   = {w_new64[31:0], r_mcycle[31:0]};
                ADDR_MINSTRET:  w_instret_nxt = (XLEN == 32) ? {r_minstret[63:32], w_new64[31:0]} : w_new64;
                ADDR_MINSTRETH: w_instret_nxt = {w_new64[31:0], r_minstret[31:0]};
                default: ;
            endcase
        end
    end

    assign w_tv_base   = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_tv_off    = (r_mtvec[1:0] == 2'b01 && trap_cause[XLEN-1]) ?
                         XLEN'({trap_cause[XLEN-2:0], 2'b00}) : '0;
    assign trap_vector = w_tv_base + w_tv_off;
    assign epc_out     = r_mepc;
    assign mie_out     = r_mie;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mcycle   <= w_cycle_nxt;
            r_minstret <= w_instret_nxt;
            if (w_wr && csr_addr == ADDR_MTVEC) begin
                r_mtvec <= {w_new[XLEN-1:2], w_new[1] ? r_mtvec[1:0] : w_new[1:0]};
            end
            if (w_wr && csr_addr == ADDR_MSCRATCH) begin
                r_mscratch <= w_new;
            end
            // Trap and mret own mstatus/mepc/mcause/mtval over software writes.
            if (trap_valid) begin
                r_mepc   <= trap_pc & ~XLEN'(3);
                r_mcause <= trap_cause;
                r_mtval  <= trap_val;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (mret_valid) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
            end else if (w_wr) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                    end
                    ADDR_MEPC:   r_mepc   <= w_new & ~XLEN'(3);
                    ADDR_MCAUSE: r_mcause <= w_new;
                    ADDR_MTVAL:  r_mtval  <= w_new;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file (XLEN=32): directed scenarios then random traffic
// compared against a behavioural CSR model.
module tb_csr_file;

    localparam int          XLEN    = 32;
    localparam logic [31:0] MTV_RST = 32'h0000_0104;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_valid;
    logic        instret_inc;
    logic [31:0] trap_vector;
    logic [31:0] epc_out;
    logic        mie_out;

    csr_file #(.XLEN(XLEN), .MTVEC_RESET(MTV_RST)) dut (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_val(trap_val), .mret_valid(mret_valid), .instret_inc(instret_inc),
        .trap_vector(trap_vector), .epc_out(epc_out), .mie_out(mie_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        ill;
        logic [31:0] tv;
        logic [31:0] epc;
        logic        mie;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Behavioural architectural state
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cyc, m_ins;

    function automatic logic implemented(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'hB00, 12'hB02, 12'hB80, 12'hB82};
    endfunction

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mvector();
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[1:0] == 2'd1 && trap_cause[31]) return base + (trap_cause << 2);
        return base;
    endfunction

    task automatic model_edge();
        logic [31:0] old, nv;
        logic        wr, ctl_ok, prev_mie;
        logic [63:0] cyc_n, ins_n;
        if (!rst_n) begin
            m_mie = 0; m_mpie = 0; m_mtvec = MTV_RST; m_scratch = 0;
            m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        old = mread(csr_addr);
        nv  = (csr_op == 2'b01) ? csr_wdata :
              (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
        wr     = (csr_op != 2'b00) && implemented(csr_addr);
        ctl_ok = !trap_valid && !mret_valid;
        cyc_n  = m_cyc + 1;
        ins_n  = m_ins + (instret_inc ? 64'd1 : 64'd0);
        if (wr) begin
            case (csr_addr)
                12'h300: if (ctl_ok) begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = {nv[31:2], (nv[1:0] < 2) ? nv[1:0] : m_mtvec[1:0]};
                12'h340: m_scratch = nv;
                12'h341: if (ctl_ok) m_epc = nv & 32'hFFFF_FFFC;
                12'h342: if (ctl_ok) m_cause = nv;
                12'h343: if (ctl_ok) m_tval = nv;
                12'hB00: cyc_n = {m_cyc[63:32], nv};
                12'hB80: cyc_n = {nv, m_cyc[31:0]};
                12'hB02: ins_n = {m_ins[63:32], nv};
                12'hB82: ins_n = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = cyc_n;
        m_ins = ins_n;
        if (trap_valid) begin
            prev_mie = m_mie;
            m_epc = trap_pc & 32'hFFFF_FFFC; m_cause = trap_cause; m_tval = trap_val;
            m_mpie = prev_mie; m_mie = 0;
        end else if (mret_valid) begin
            m_mie = m_mpie; m_mpie = 1;
        end
    endtask

    // One clock of stimulus; trap_cause/pc/val are taken from whatever is currently driven.
    task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                        input logic tv, input logic mv, input logic inc, input logic rst,
                        input logic chk, input string tag);
        exp_t e;
        rst_n = rst; csr_addr = a; csr_op = op; csr_wdata = wd;
        trap_valid = tv; mret_valid = mv; instret_inc = inc;
        if (chk) begin
            e.tag = tag; e.rd = mread(a); e.ill = (op != 2'b00) && !implemented(a);
            e.tv = mvector(); e.epc = m_epc; e.mie = m_mie;
            sb.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input string tag);
        step(a, 2'b00, 32'h0, 0, 0, 0, 1, 1, tag);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d, input string tag);
        step(a, op, d, 0, 0, 0, 1, 1, tag);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.tag, ".rdata"},   csr_rdata,          e.rd);
            cmp({e.tag, ".illegal"}, 32'(csr_illegal),   32'(e.ill));
            cmp({e.tag, ".vector"},  trap_vector,        e.tv);
            cmp({e.tag, ".epc"},     epc_out,            e.epc);
            cmp({e.tag, ".mie"},     32'(mie_out),       32'(e.mie));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [12];
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h301};
        rst_n = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0; trap_valid = 0;
        trap_cause = 0; trap_pc = 0; trap_val = 0; mret_valid = 0; instret_inc = 0;

        step(12'h0, 2'b00, 32'h0, 0, 0, 0, 0, 0, "rst0");
        step(12'h300, 2'b00, 32'h0, 0, 0, 0, 0, 1, "rst1");
        for (int i = 0; i < 12; i++) rd(addrs[i], "reset_read");

        wr(12'h300, 2'b01, 32'hFFFF_FFFF, "mstatus_wr");
        rd(12'h300, "mstatus_all");
        wr(12'h300, 2'b11, 32'h0000_0008, "mstatus_clr");
        rd(12'h300, "mstatus_after_clr");

        wr(12'h305, 2'b01, 32'h0000_1001, "mtvec_wr");
        trap_cause = 32'h8000_0007;
        rd(12'h305, "vec_irq7");
        trap_cause = 32'h0000_0002;
        rd(12'h305, "vec_exc2");
        wr(12'h305, 2'b01, 32'h0000_2003, "mtvec_mode3");
        rd(12'h305, "mtvec_keep_mode");

        wr(12'h300, 2'b10, 32'h0000_0008, "mie_set");
        trap_pc = 32'h0000_8003; trap_cause = 32'h2; trap_val = 32'h0000_DEAD;
        step(12'h300, 2'b00, 32'h0, 1, 0, 0, 1, 1, "trap");
        rd(12'h341, "trap_mepc");
        rd(12'h342, "trap_mcause");
        rd(12'h343, "trap_mtval");
        rd(12'h300, "trap_mstatus");
        step(12'h300, 2'b00, 32'h0, 0, 1, 0, 1, 1, "mret");
        rd(12'h300, "mret_mstatus");

        trap_pc = 32'h0000_4447;
        step(12'h341, 2'b01, 32'h0000_1234, 1, 0, 1, 1, 1, "trap_vs_wr");
        rd(12'h341, "trap_vs_wr_mepc");

        wr(12'hB80, 2'b01, 32'h0, "mcycleh_wr");
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF, "mcycle_wr");
        rd(12'hB00, "mcycle_max");
        rd(12'hB00, "mcycle_wrap");
        rd(12'hB80, "mcycleh_carry");
        wr(12'hB00, 2'b01, 32'h5, "mcycle_wr5");
        rd(12'hB00, "mcycle_5");
        rd(12'hB00, "mcycle_6");
        step(12'hB02, 2'b01, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, "minstret_wr");
        step(12'hB02, 2'b00, 32'h0, 0, 0, 1, 1, 1, "minstret_inc");
        rd(12'hB82, "minstreth_carry");

        wr(12'h7C0, 2'b01, 32'hFFFF_FFFF, "illegal_wr");
        rd(12'h340, "illegal_nochg");
        wr(12'h340, 2'b01, 32'hCAFE_F00D, "scratch_wr");
        trap_pc = 32'h0000_9000;
        step(12'h340, 2'b01, 32'h1111_1111, 1, 0, 1, 0, 1, "rst_trap");
        for (int i = 0; i < 12; i++) rd(addrs[i], "post_rst");

        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            logic        tv, mv, rs;
            a  = addrs[$urandom_range(0, 11)];
            tv = ($urandom_range(0, 7) == 0);
            mv = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 63) != 0);
            trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
            step(a, 2'($urandom_range(0, 3)), $urandom, tv, mv, 1'($urandom_range(0, 1)),
                 rs, 1, "rand");
        end

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter: MTVEC_RESET, default 0, reset value of mtvec (mode bits included).
REQ-003 Clock and reset are one clock, clk, rising-edge; reset is synchronous and active-low, rst_n.
REQ-004 Ports (name  direction  width  meaning):
  clk  in  1  clock
  rst_n  in  1  synchronous active-low reset
  csr_addr  in  12  CSR address
  csr_op  in  2  00 none, 01 write, 10 set bits, 11 clear bits
  csr_wdata  in  XLEN  write/set/clear operand
  csr_rdata  out  XLEN  combinational read of addressed CSR (pre-update value)
  csr_illegal  out  1  addressed CSR not implemented while csr_op != 00
  trap_valid  in  1  take trap this cycle
  trap_cause  in  XLEN  cause value; MSB = interrupt
  trap_pc  in  XLEN  faulting PC
  trap_val  in  XLEN  trap value
  mret_valid  in  1  return from trap this cycle
  instret_inc  in  1  one instruction retired this cycle
  trap_vector  out  XLEN  redirect target for current trap_cause
  epc_out  out  XLEN  current mepc
  mie_out  out  1  current mstatus.MIE

Function
REQ-005 Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02; when XLEN=32 also mcycleh 0xB80, minstreth 0xB82.
REQ-006 Any other address, or 0xB80/0xB82 when XLEN=64, SHALL read 0, assert csr_illegal (if csr_op != 00), and leave all state unchanged.
REQ-007 New value = wdata (01), old|wdata (10), old&~wdata (11); committed on the next rising clk edge.
REQ-008 mstatus: only MIE (bit 3) and MPIE (bit 7) writable; MPP (bits 12:11) always reads 2'b11; all other bits read 0.
REQ-009 mtvec: base bits [XLEN-1:2] writable; mode [1:0] accepts 0 (direct) or 1 (vectored); a mode value of 2 or 3 retains the previous mode while the base still updates.
REQ-010 mepc: bits [1:0] always read 0; mcause, mtval, mscratch fully writable.
REQ-011 mcycle: 64-bit counter, +1 every cycle; minstret: 64-bit counter, +1 when instret_inc=1; both wrap from all-ones to 0.
REQ-012 XLEN=32: mcycle/minstret access bits [31:0], mcycleh/minstreth access bits [63:32]; XLEN=64: full 64 bits.
REQ-013 A CSR write to a counter half SHALL take precedence over that counter's increment in the same cycle; the other half holds its value (no carry into or out of it).
REQ-014 trap_valid=1: mepc<=trap_pc with [1:0] cleared, mcause<=trap_cause, mtval<=trap_val, MPIE<=MIE, MIE<=0.
REQ-015 mret_valid=1 (without trap_valid): MIE<=MPIE, MPIE<=1.
REQ-016 Priority: trap_valid > mret_valid > CSR write for mstatus/mepc/mcause/mtval; a CSR write to mtvec, mscratch or the counters still commits in a trap or mret cycle.
REQ-017 trap_vector: mtvec base<<2 when mode=0 or trap_cause MSB=0; base<<2 + 4*trap_cause[XLEN-2:0] when mode=1 and MSB=1; combinational.
REQ-018 csr_rdata, csr_illegal, trap_vector, epc_out and mie_out are combinational and reflect register state before the current edge.

Reset
REQ-019 rst_n=0 at a rising edge: mstatus.MIE=0, MPIE=0; mtvec=MTVEC_RESET; mscratch, mepc, mcause, mtval, mcycle, minstret = 0.
REQ-020 Reset SHALL override trap_valid, mret_valid, CSR writes and counter increments in the same cycle.
REQ-021 Outputs after reset: csr_rdata reads 0 for every address except mstatus (0x1800) and mtvec; csr_illegal follows REQ-006.

Verification
REQ-022 Write 0x300 with 0xFFFFFFFF, then read 0x300 -> 0x00001888; then clear 0x8 -> 0x00001880, mie_out=0.
REQ-023 mtvec=0x1001 (vectored), trap_cause=0x80000007 -> trap_vector=0x101C; with trap_cause=0x2 -> trap_vector=0x1000; then write mode 3 -> mode remains 1.
REQ-024 MIE=1; trap_valid with trap_pc=0x8003, cause=2, val=0xDEAD -> mepc=0x8000, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
REQ-025 Same cycle: trap_valid=1 and CSR write of 0x1234 to mepc -> mepc equals trap_pc (masked), not 0x1234; csr_illegal=0.
REQ-026 XLEN=32: mcycle=0xFFFFFFFF, mcycleh=0 -> next cycle mcycle=0, mcycleh=1; write mcycle=5 while incrementing -> reads 5 the following cycle, then 6.
REQ-027 Access 0x7C0 with csr_op=01 -> csr_illegal=1, csr_rdata=0, no state change; drive rst_n=0 during a trap cycle -> all state at reset values.
